instr_fetch: RTL

//  Instruction fetch sequencer sitting between the program counter and the instruction decoder.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instr_fetch.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : FSM encoding (SETTLE / FETCH / HOLD)
//   LEN_*         : instruction length codes
//   instr_len()   : length of an instruction from the top two opcode bits
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2
    } fetch_state_t;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // op_hi = opcode[7:6]; 2'b11 is reserved and treated as a 1-byte instruction
    function automatic logic [1:0] instr_len(input logic [1:0] op_hi);
        case (op_hi)
            2'b01:   instr_len = LEN_2;
            2'b10:   instr_len = LEN_3;
            default: instr_len = LEN_1;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer between the program counter and the decoder.
// Reads bytes from program memory at pc_in over a req/ack handshake, pulses
// pc_inc once per accepted byte and presents assembled 1..3 byte
// instructions to the decoder on a valid/ready handshake.
//
// Ports:
//   clk, reset            clock (posedge), asynchronous active-high reset
//   pc_in                 current program counter
//   pc_inc                one-cycle pulse: advance the PC by one
//   mem_addr, mem_req     fetch address / request (held until mem_ack)
//   mem_ack, mem_data     read completion and data
//   flush                 PC rewritten: abort whatever is in progress
//   ir_valid, ir_ready    instruction handshake towards the decoder
//   ir_opcode/arg0/arg1   instruction bytes (unused bytes read 0)
//   ir_len, ir_pc         length 1..3 and address of the opcode byte
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_arg0,
    output logic [DATA_W-1:0] ir_arg1,
    output logic [1:0]        ir_len,
    output logic [ADDR_W-1:0] ir_pc
);

    fetch_state_t state, next_state;
    logic [1:0]   byte_cnt;
    logic [1:0]   cur_len;
    logic         take_ack;

    // mem_req and ir_valid decode straight from the state register, so an
    // asynchronous reset clears them immediately.
    assign mem_req  = (state == ST_FETCH);
    assign ir_valid = (state == ST_HOLD);
    assign mem_addr = mem_req ? pc_in : '0;

    always_comb begin
        next_state = state;
        // An ack only counts while requesting, and a coincident flush discards it.
        take_ack   = (state == ST_FETCH) && mem_ack && !flush;
        // For the opcode byte the length is not registered yet, so take it from the bus.
        cur_len    = (byte_cnt == 2'd0) ? instr_len(mem_data[DATA_W-1 -: 2]) : ir_len;

        case (state)
            ST_SETTLE: next_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)
                    next_state = ((byte_cnt + 2'd1) == cur_len) ? ST_HOLD : ST_SETTLE;
            end
            ST_HOLD: begin
                // PC was advanced by the last pc_inc, so refetch without settling.
                if (ir_ready)
                    next_state = ST_FETCH;
            end
            default: next_state = ST_SETTLE;
        endcase

        if (flush)
            next_state = ST_SETTLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SETTLE;
            byte_cnt  <= 2'd0;
            pc_inc    <= 1'b0;
            ir_opcode <= '0;
            ir_arg0   <= '0;
            ir_arg1   <= '0;
            ir_len    <= 2'd0;
            ir_pc     <= '0;
        end else begin
            state  <= next_state;
            pc_inc <= take_ack;

            if (flush) begin
                byte_cnt <= 2'd0;
            end else if (take_ack) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: begin
                        ir_opcode <= mem_data;
                        ir_arg0   <= '0;
                        ir_arg1   <= '0;
                        ir_len    <= cur_len;
                        ir_pc     <= pc_in;
                    end
                    2'd1:    ir_arg0 <= mem_data;
                    default: ir_arg1 <= mem_data;
                endcase
            end else if (state == ST_HOLD && ir_ready) begin
                byte_cnt <= 2'd0;
            end
        end
    end

endmodule
